// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared widths, saturation limits, state encoding and packing helper for mat_mult_seq
package mm_pkg;

    localparam int DW_DEF    = 8;
    localparam int MAX_N_DEF = 5;

    // Accumulator wide enough that MAX_N full-scale products never lose bits.
    function automatic int acc_width(input int dw, input int max_n);
        return 2 * dw + $clog2(max_n) + 1;
    endfunction

    function automatic longint sat_max(input int dw);
        return (longint'(1) <<< (dw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

    localparam int     ACC_W   = acc_width(DW_DEF, MAX_N_DEF);
    localparam longint SAT_MAX = sat_max(DW_DEF);
    localparam longint SAT_MIN = sat_min(DW_DEF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        FINISH  = 2'd2
    } state_t;

    // Row-major packing: element (0,0) occupies the most significant slot.
    function automatic int elem_lsb(input int i, input int j, input int max_n, input int dw);
        return (max_n * max_n - 1 - (i * max_n + j)) * dw;
    endfunction

endpackage

// File: rtl/mm_dot.sv
// rtl/mm_dot.sv - combinational MAX_N-lane signed dot product with lane mask from n
module mm_dot
    import mm_pkg::*;
#(
    parameter int DW    = 8,
    parameter int MAX_N = 5,
    parameter int AW    = acc_width(DW, MAX_N)
) (
    input  logic [MAX_N*DW-1:0]   row,
    input  logic [MAX_N*DW-1:0]   col,
    input  logic [2:0]            n,
    output logic signed [AW-1:0]  sum
);

    logic signed [2*DW-1:0] prod [MAX_N];

    // Per-lane full-precision signed products; lane 0 is the most significant slot.
    always_comb begin
        for (int k = 0; k < MAX_N; k++) begin
            prod[k] = (2*DW)'($signed(row[(MAX_N-1-k)*DW +: DW]))
                    * (2*DW)'($signed(col[(MAX_N-1-k)*DW +: DW]));
        end
    end

    // Sign-extended accumulation; lanes at or beyond n contribute nothing.
    always_comb begin
        sum = '0;
        for (int k = 0; k < MAX_N; k++) begin
            if (k < int'(n)) begin
                sum = sum + AW'(prod[k]);
            end
        end
    end

endmodule

// File: rtl/mat_mult_seq.sv
// rtl/mat_mult_seq.sv - sequential square matrix multiplier, one result element per cycle
module mat_mult_seq
    import mm_pkg::*;
#(
    parameter int DW    = 8,
    parameter int MAX_N = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [2:0]                size,
    input  logic                      sat_en,
    input  logic [MAX_N*MAX_N*DW-1:0] mat_a,
    input  logic [MAX_N*MAX_N*DW-1:0] mat_b,
    output logic                      busy,
    output logic                      done,
    output logic [MAX_N*MAX_N*DW-1:0] result,
    output logic                      ovf,
    output logic                      err
);

    localparam int AW  = acc_width(DW, MAX_N);
    localparam int TOT = MAX_N * MAX_N * DW;
    localparam logic signed [AW-1:0] LIM_HI = AW'(sat_max(DW));
    localparam logic signed [AW-1:0] LIM_LO = AW'(sat_min(DW));

    state_t                state_q, state_d;
    logic [TOT-1:0]        a_q, b_q;
    logic [2:0]            n_q;
    logic                  sat_q;
    logic [2:0]            i_q, j_q;
    logic [MAX_N*DW-1:0]   row_vec, col_vec;
    logic signed [AW-1:0]  dot_sum;
    logic                  over;
    logic [DW-1:0]         elem;
    logic                  size_ok;
    logic                  last_elem;

    assign size_ok   = (size != 3'd0) && (int'(size) <= MAX_N);
    assign last_elem = (i_q == n_q - 3'd1) && (j_q == n_q - 3'd1);

    // Gather row i of A and column j of B from the captured operands.
    always_comb begin
        row_vec = '0;
        col_vec = '0;
        for (int k = 0; k < MAX_N; k++) begin
            row_vec[(MAX_N-1-k)*DW +: DW] = a_q[elem_lsb(int'(i_q), k, MAX_N, DW) +: DW];
            col_vec[(MAX_N-1-k)*DW +: DW] = b_q[elem_lsb(k, int'(j_q), MAX_N, DW) +: DW];
        end
    end

    mm_dot #(
        .DW    (DW),
        .MAX_N (MAX_N),
        .AW    (AW)
    ) u_dot (
        .row (row_vec),
        .col (col_vec),
        .n   (n_q),
        .sum (dot_sum)
    );

    // Range check and saturate-or-wrap reduction of the accumulator to DW bits.
    always_comb begin
        over = (dot_sum > LIM_HI) || (dot_sum < LIM_LO);
        elem = dot_sum[DW-1:0];
        if (over && sat_q) begin
            elem = (dot_sum > LIM_HI) ? LIM_HI[DW-1:0] : LIM_LO[DW-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; invalid sizes skip straight to FINISH.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = size_ok ? COMPUTE : FINISH;
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                if (last_elem) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, element write-back, sticky flags and index walk.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            n_q    <= '0;
            sat_q  <= 1'b0;
            i_q    <= '0;
            j_q    <= '0;
            result <= '0;
            ovf    <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        result <= '0;
                        ovf    <= 1'b0;
                        i_q    <= '0;
                        j_q    <= '0;
                        if (size_ok) begin
                            a_q   <= mat_a;
                            b_q   <= mat_b;
                            n_q   <= size;
                            sat_q <= sat_en;
                            err   <= 1'b0;
                        end else begin
                            err   <= 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    result[elem_lsb(int'(i_q), int'(j_q), MAX_N, DW) +: DW] <= elem;
                    if (over) begin
                        ovf <= 1'b1;
                    end
                    if (j_q == n_q - 3'd1) begin
                        j_q <= '0;
                        i_q <= i_q + 3'd1;
                    end else begin
                        j_q <= j_q + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
